// File: rtl/umi_merge_arbiter.sv
// Round-robin arbiter that locks one UMI requester onto the merge datapath
// until end-of-message, a packet budget, or an idle timeout releases it.
module umi_merge_arbiter #(
   parameter int unsigned N       = 4,
   parameter int unsigned CW      = 32,
   parameter int unsigned AW      = 64,
   parameter int unsigned DW      = 64,
   parameter int unsigned MAXPKT  = 16,
   parameter int unsigned TIMEOUT = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    umi_in_valid,
   input  logic [N*CW-1:0] umi_in_cmd,
   input  logic [N*AW-1:0] umi_in_dstaddr,
   input  logic [N*AW-1:0] umi_in_srcaddr,
   input  logic [N*DW-1:0] umi_in_data,
   output logic [N-1:0]    umi_in_ready,
   output logic            umi_out_valid,
   output logic [CW-1:0]   umi_out_cmd,
   output logic [AW-1:0]   umi_out_dstaddr,
   output logic [AW-1:0]   umi_out_srcaddr,
   output logic [DW-1:0]   umi_out_data,
   input  logic            umi_out_ready,
   output logic [N-1:0]    grant
);

   localparam int unsigned GW      = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned PW      = $clog2(MAXPKT + 1);
   localparam int unsigned IW      = $clog2(TIMEOUT + 1);
   localparam int unsigned EOM_BIT = 22;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t        state, state_nxt;
   logic [GW-1:0] last_grant, last_grant_nxt;
   logic [N-1:0]  grant_nxt;
   logic [PW-1:0] pkt_cnt, pkt_cnt_nxt;
   logic [IW-1:0] idle_cnt, idle_cnt_nxt;
   logic          release_c;

   logic          sel_valid;
   logic [CW-1:0] sel_cmd;
   logic [AW-1:0] sel_dstaddr;
   logic [AW-1:0] sel_srcaddr;
   logic [DW-1:0] sel_data;
   logic          commit;

   logic [GW-1:0] pick;
   logic          pick_found;

   // Select the bundle of the current owner; last_grant holds the owner index while locked
   always_comb begin
      sel_valid   = 1'b0;
      sel_cmd     = '0;
      sel_dstaddr = '0;
      sel_srcaddr = '0;
      sel_data    = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (last_grant == GW'(i)) begin
            sel_valid   = umi_in_valid[i];
            sel_cmd     = umi_in_cmd[i*CW +: CW];
            sel_dstaddr = umi_in_dstaddr[i*AW +: AW];
            sel_srcaddr = umi_in_srcaddr[i*AW +: AW];
            sel_data    = umi_in_data[i*DW +: DW];
         end
      end
      commit = (state == LOCKED) && sel_valid && umi_out_ready;
   end

   // First valid requester searching upward from last_grant+1 with wrap-around
   always_comb begin
      logic [GW-1:0] idx;
      pick       = '0;
      pick_found = 1'b0;
      idx        = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx = GW'((32'(last_grant) + k) % N);
         if (!pick_found && umi_in_valid[idx]) begin
            pick_found = 1'b1;
            pick       = idx;
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= GW'(N - 1);
         pkt_cnt    <= '0;
         idle_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
         pkt_cnt    <= pkt_cnt_nxt;
         idle_cnt   <= idle_cnt_nxt;
      end
   end

   // Next-state: arbitration in IDLE, budget/timeout tracking in LOCKED
   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      pkt_cnt_nxt    = pkt_cnt;
      idle_cnt_nxt   = idle_cnt;
      release_c      = 1'b0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_nxt      = LOCKED;
               last_grant_nxt = pick;
               grant_nxt      = N'(1) << pick;
               pkt_cnt_nxt    = '0;
               idle_cnt_nxt   = '0;
            end
         end
         LOCKED: begin
            if (commit) begin
               pkt_cnt_nxt  = pkt_cnt + PW'(1);
               idle_cnt_nxt = '0;
            end else if (!sel_valid && (idle_cnt != IW'(TIMEOUT))) begin
               idle_cnt_nxt = idle_cnt + IW'(1);
            end
            // Any combination of eom, budget and timeout yields one release
            release_c = (commit && (sel_cmd[EOM_BIT] || (pkt_cnt_nxt == PW'(MAXPKT))))
                        || (idle_cnt_nxt == IW'(TIMEOUT));
            if (release_c) begin
               state_nxt = IDLE;
               grant_nxt = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   // Outputs: zero-latency pass-through of the owner, nothing moves in IDLE
   always_comb begin
      umi_out_valid   = 1'b0;
      umi_out_cmd     = sel_cmd;
      umi_out_dstaddr = sel_dstaddr;
      umi_out_srcaddr = sel_srcaddr;
      umi_out_data    = sel_data;
      umi_in_ready    = '0;
      if (state == LOCKED) begin
         umi_out_valid            = sel_valid;
         umi_in_ready[last_grant] = umi_out_ready;
      end
   end

endmodule

// File: tb/tb_umi_merge_arbiter.sv
// Self-checking bench for umi_merge_arbiter: directed vector table, corner-case
// sequences, then randomized traffic against a packet-level reference model.
module tb_umi_merge_arbiter;

   localparam int N       = 4;
   localparam int CW      = 32;
   localparam int AW      = 64;
   localparam int DW      = 64;
   localparam int MAXPKT  = 4;
   localparam int TIMEOUT = 8;

   logic            clk;
   logic            reset;
   logic [N-1:0]    v;
   logic [N*CW-1:0] in_cmd;
   logic [N*AW-1:0] in_dst;
   logic [N*AW-1:0] in_src;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_ready;
   logic            out_valid;
   logic [CW-1:0]   out_cmd;
   logic [AW-1:0]   out_dst;
   logic [AW-1:0]   out_src;
   logic [DW-1:0]   out_data;
   logic            rdy;
   logic [N-1:0]    grant;

   logic [CW-1:0] cmd_a  [N];
   logic [AW-1:0] dst_a  [N];
   logic [AW-1:0] src_a  [N];
   logic [DW-1:0] data_a [N];

   int errors = 0;
   int checks = 0;

   umi_merge_arbiter #(
      .N(N), .CW(CW), .AW(AW), .DW(DW), .MAXPKT(MAXPKT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .umi_in_valid   (v),
      .umi_in_cmd     (in_cmd),
      .umi_in_dstaddr (in_dst),
      .umi_in_srcaddr (in_src),
      .umi_in_data    (in_data),
      .umi_in_ready   (in_ready),
      .umi_out_valid  (out_valid),
      .umi_out_cmd    (out_cmd),
      .umi_out_dstaddr(out_dst),
      .umi_out_srcaddr(out_src),
      .umi_out_data   (out_data),
      .umi_out_ready  (rdy),
      .grant          (grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         in_cmd[i*CW +: CW]  = cmd_a[i];
         in_dst[i*AW +: AW]  = dst_a[i];
         in_src[i*AW +: AW]  = src_a[i];
         in_data[i*DW +: DW] = data_a[i];
      end
   end

   typedef struct {
      logic       rst;
      logic [3:0] valid;
      logic [3:0] eom;
      logic       ordy;
      logic [3:0] g;
      logic       ov;
      logic [3:0] ir;
      int         src;
   } vec_t;

   vec_t tbl [16];

   function automatic logic [63:0] tag(input int i);
      return {32'hA5A5_0000, 32'(i)};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] vv, input logic [3:0] ee, input logic r);
      v = vv;
      for (int i = 0; i < N; i++) begin
         cmd_a[i]      = 32'h0000_1000 | 32'(i);
         cmd_a[i][22]  = ee[i];
         dst_a[i]      = 64'(i) << 8;
         src_a[i]      = 64'(i) << 16;
         data_a[i]     = tag(i);
      end
      rdy = r;
   endtask

   task automatic expect_cyc(input string nm, input logic [3:0] g, input logic ov,
                             input logic [3:0] ir);
      @(negedge clk);
      chk({nm, "_grant"}, 64'(grant), 64'(g));
      chk({nm, "_ovalid"}, 64'(out_valid), 64'(ov));
      chk({nm, "_iready"}, 64'(in_ready), 64'(ir));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(4'b0000, 4'b0000, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Reference model: packet-level ownership bookkeeping
   int   owner;
   int   last;
   int   pkts;
   int   idles;
   logic pend [N];

   task automatic model_check();
      logic [3:0] eg, eir;
      logic       eov;
      eg  = (owner < 0) ? 4'b0 : 4'(1 << owner);
      eov = (owner >= 0) && v[owner];
      eir = (owner >= 0 && rdy) ? 4'(1 << owner) : 4'b0;
      chk("rnd_grant", 64'(grant), 64'(eg));
      chk("rnd_ovalid", 64'(out_valid), 64'(eov));
      chk("rnd_iready", 64'(in_ready), 64'(eir));
      if (eov) begin
         chk("rnd_cmd", 64'(out_cmd), 64'(cmd_a[owner]));
         chk("rnd_dst", out_dst, dst_a[owner]);
         chk("rnd_src", out_src, src_a[owner]);
         chk("rnd_data", out_data, data_a[owner]);
      end
   endtask

   task automatic model_step();
      logic commit, eom;
      if (owner < 0) begin
         for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (owner < 0 && v[idx]) begin
               owner = idx;
               last  = idx;
               pkts  = 0;
               idles = 0;
            end
         end
      end else begin
         commit = v[owner] && rdy;
         eom    = cmd_a[owner][22];
         if (commit) begin
            pkts++;
            idles = 0;
            pend[owner] = 1'b0;
         end else if (!v[owner] && idles < TIMEOUT) begin
            idles++;
         end
         if ((commit && (eom || pkts == MAXPKT)) || idles == TIMEOUT) owner = -1;
      end
   endtask

   initial begin
      // rst valid  eom  ordy grant ov iready src
      tbl[0]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, -1};
      tbl[1]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'b0001,  0};
      tbl[2]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'b0001,  0};
      tbl[3]  = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0001,  0};
      tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, -1};
      tbl[5]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000, -1};
      tbl[6]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000, -1};
      tbl[7]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001,  0};
      tbl[8]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000, -1};
      tbl[9]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010,  1};
      tbl[10] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000, -1};
      tbl[11] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100,  2};
      tbl[12] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000, -1};
      tbl[13] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1000,  3};
      tbl[14] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000, -1};
      tbl[15] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001,  0};

      // Reset state with requests already pending
      reset = 1'b1;
      drive(4'b1111, 4'b0000, 1'b1);
      @(negedge clk);
      chk("reset_grant", 64'(grant), 64'(0));
      chk("reset_ovalid", 64'(out_valid), 64'(0));
      chk("reset_iready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(4'b0000, 4'b0000, 1'b1);

      // Single-requester stream, then round-robin across all four
      for (int r = 0; r < 16; r++) begin
         reset = tbl[r].rst;
         drive(tbl[r].valid, tbl[r].eom, tbl[r].ordy);
         @(negedge clk);
         chk($sformatf("tbl%0d_grant", r), 64'(grant), 64'(tbl[r].g));
         chk($sformatf("tbl%0d_ovalid", r), 64'(out_valid), 64'(tbl[r].ov));
         chk($sformatf("tbl%0d_iready", r), 64'(in_ready), 64'(tbl[r].ir));
         if (tbl[r].src >= 0) chk($sformatf("tbl%0d_data", r), out_data, tag(tbl[r].src));
         @(posedge clk);
         #1;
      end

      // Packet budget: req1 and req2 stream without eom
      do_reset();
      drive(4'b0110, 4'b0000, 1'b1);
      expect_cyc("bud_arb0", 4'b0000, 1'b0, 4'b0000);
      for (int i = 0; i < MAXPKT; i++) expect_cyc("bud_req1", 4'b0010, 1'b1, 4'b0010);
      expect_cyc("bud_gap1", 4'b0000, 1'b0, 4'b0000);
      for (int i = 0; i < MAXPKT; i++) expect_cyc("bud_req2", 4'b0100, 1'b1, 4'b0100);
      expect_cyc("bud_gap2", 4'b0000, 1'b0, 4'b0000);
      expect_cyc("bud_regrant1", 4'b0010, 1'b1, 4'b0010);

      // Idle timeout: req3 sends one packet then goes quiet
      do_reset();
      drive(4'b1000, 4'b0000, 1'b1);
      expect_cyc("to_arb", 4'b0000, 1'b0, 4'b0000);
      expect_cyc("to_commit", 4'b1000, 1'b1, 4'b1000);
      v = 4'b0000;
      for (int i = 0; i < TIMEOUT; i++) expect_cyc("to_held", 4'b1000, 1'b0, 4'b1000);
      expect_cyc("to_release", 4'b0000, 1'b0, 4'b0000);

      // Backpressure longer than the timeout must not release a valid owner
      do_reset();
      drive(4'b0001, 4'b0000, 1'b0);
      expect_cyc("bp_arb", 4'b0000, 1'b0, 4'b0000);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_grant", 64'(grant), 64'(4'b0001));
         chk("bp_ovalid", 64'(out_valid), 64'(1));
         chk("bp_iready", 64'(in_ready), 64'(0));
         chk("bp_data", out_data, tag(0));
         chk("bp_cmd", 64'(out_cmd), 64'(32'h0000_1000));
         @(posedge clk);
         #1;
      end
      rdy = 1'b1;
      expect_cyc("bp_commit", 4'b0001, 1'b1, 4'b0001);
      v = 4'b0000;
      expect_cyc("bp_still_owned", 4'b0001, 1'b0, 4'b0001);

      // Reset mid-grant with three packets committed
      do_reset();
      drive(4'b0100, 4'b0000, 1'b1);
      expect_cyc("rmg_arb", 4'b0000, 1'b0, 4'b0000);
      for (int i = 0; i < 3; i++) expect_cyc("rmg_pkt", 4'b0100, 1'b1, 4'b0100);
      reset = 1'b1;
      expect_cyc("rmg_reset", 4'b0000, 1'b0, 4'b0000);
      reset = 1'b0;
      drive(4'b1111, 4'b0000, 1'b1);
      expect_cyc("rmg_arb2", 4'b0000, 1'b0, 4'b0000);
      expect_cyc("rmg_req0_first", 4'b0001, 1'b1, 4'b0001);

      // Randomized traffic against the reference model
      do_reset();
      owner = -1;
      last  = N - 1;
      pkts  = 0;
      idles = 0;
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i]       = 1'b1;
               cmd_a[i]      = $urandom;
               cmd_a[i][22]  = ($urandom_range(0, 3) == 0);
               dst_a[i]      = {$urandom, $urandom};
               src_a[i]      = {$urandom, $urandom};
               data_a[i]     = {$urandom, $urandom};
            end
            v[i] = pend[i];
         end
         rdy = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         model_check();
         model_step();
         @(posedge clk);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
